binary_multiplier: RTL and testbench

- Sequential shift-and-add unsigned multiplier. It is the inverse datapath of the team's binary divider.
- It reconstructs products such as quotient × divisor for the same fixed-point path. Example use: dividend-consistency checks and rescaling after division.
- It uses the same enable/done start-complete handshake and the same IDLE/RUN/COMPLETE FSM style as the divider.
- It processes one multiplier bit per clock.

---
 rtl/binary_multiplier_pkg.sv | 19 +
 rtl/binary_multiplier.sv | 125 ++++++++++++
 tb/tb_binary_multiplier.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/binary_multiplier_pkg.sv
// Shared definitions for the fixed-point divide/multiply datapath:
// FSM state encoding and default operand widths.
package binary_multiplier_pkg;

  // Default widths: multiplicand matches the divider's divisor width,
  // multiplier matches the divider's quotient width.
  localparam int DEF_A_W   = 16;
  localparam int DEF_B_W   = 8;
  localparam int DEF_OUT_W = 16;

  // Start/run/complete sequencing shared with binary_divider.
  // Code 2'b10 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    COMPLETE = 2'b11
  } mul_state_e;

endpackage : binary_multiplier_pkg

// File: rtl/binary_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// An operation runs for exactly B_W iterations and then one COMPLETE cycle
// that registers the full product, a saturated copy and an overflow flag.
module binary_multiplier
  import binary_multiplier_pkg::*;
#(
  parameter  int A_W   = DEF_A_W,
  parameter  int B_W   = DEF_B_W,
  parameter  int OUT_W = DEF_OUT_W,
  localparam int P_W   = A_W + B_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [A_W-1:0]   g_multiplicand_Q,
  input  logic [B_W-1:0]   g_multiplier_Q,
  output logic [P_W-1:0]   product,
  output logic [OUT_W-1:0] product_sat,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = $clog2(B_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_W - 1);

  mul_state_e         state_q, state_d;
  logic [P_W-1:0]     acc_q, acc_d;
  logic [P_W-1:0]     mcand_q, mcand_d;
  logic [B_W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [P_W-1:0]     product_q, product_d;
  logic [OUT_W-1:0]   product_sat_q, product_sat_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               acc_ovf;

  // Any accumulator bit above the saturated field means the result does not fit.
  assign acc_ovf = (acc_q >> OUT_W) != '0;

  // Next-state, datapath iteration and result capture.
  always_comb begin
    // NOTE: every _d gets a default first; a branch that skipped one would infer a latch.
    state_d       = state_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    count_d       = count_q;
    product_d     = product_q;
    product_sat_d = product_sat_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          mcand_d  = P_W'(g_multiplicand_Q);
          mplier_d = g_multiplier_Q;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // The multiplicand is zero-extended to P_W and shifted at most
        // B_W-1 places, so this add can never carry out.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = COMPLETE;
        end
      end

      COMPLETE: begin
        product_d     = acc_q;
        overflow_d    = acc_ovf;
        product_sat_d = acc_ovf ? '1 : acc_q[OUT_W-1:0];
        done_d        = 1'b1;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      count_q       <= '0;
      product_q     <= '0;
      product_sat_q <= '0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q       <= state_d;
      acc_q         <= acc_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      count_q       <= count_d;
      product_q     <= product_d;
      product_sat_q <= product_sat_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign product     = product_q;
  assign product_sat = product_sat_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
  assign busy        = (state_q == RUN) || (state_q == COMPLETE);

endmodule : binary_multiplier

// File: tb/tb_binary_multiplier.sv
// Directed bench for binary_multiplier with default widths (16 x 8 -> 24, sat 16).
module tb_binary_multiplier;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] g_a;
  logic [7:0]  g_b;
  logic [23:0] product;
  logic [15:0] product_sat;
  logic        overflow;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  binary_multiplier dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .g_multiplicand_Q (g_a),
    .g_multiplier_Q   (g_b),
    .product          (product),
    .product_sat      (product_sat),
    .overflow         (overflow),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one operation from IDLE (called at posedge+1) and wait for done.
  // lat = edges after the start edge until done is seen, -1 on timeout.
  // busy_ok clears if busy drops before done appears.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output int lat, output bit busy_ok);
    g_a = a; g_b = b; enable = 1'b1;
    @(posedge clk); #1;
    enable  = 1'b0;
    busy_ok = busy;
    lat     = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic [23:0] e_p, input logic [15:0] e_s, input logic e_o);
    total++;
    if (lat !== 9) $display("FAIL %s latency: got %0d want 9", name, lat); else passed++;
    total++;
    if (product !== e_p) $display("FAIL %s product: got %h want %h", name, product, e_p); else passed++;
    total++;
    if (product_sat !== e_s) $display("FAIL %s product_sat: got %h want %h", name, product_sat, e_s); else passed++;
    total++;
    if (overflow !== e_o) $display("FAIL %s overflow: got %b want %b", name, overflow, e_o); else passed++;
    // done must fall after a single cycle
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) $display("FAIL %s done_width: got %b want 0", name, done); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; g_a = '0; g_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if ({product, product_sat, overflow, done, busy} !== '0)
      $display("FAIL reset_state: got p=%h s=%h o=%b d=%b b=%b want all 0",
               product, product_sat, overflow, done, busy);
    else passed++;
  endtask

  task automatic test_small();
    int lat; bit bok;
    run_op(16'd3, 8'd5, lat, bok);
    total++;
    if (bok !== 1'b1) $display("FAIL small busy: got %b want 1", bok); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL small busy_after: got %b want 0", busy); else passed++;
    check_result("small", lat, 24'd15, 16'd15, 1'b0);
  endtask

  task automatic test_max();
    int lat; bit bok;
    run_op(16'hFFFF, 8'hFF, lat, bok);
    check_result("max", lat, 24'hFEFF01, 16'hFFFF, 1'b1);
  endtask

  task automatic test_zero();
    int lat; bit bok;
    run_op(16'h1234, 8'h00, lat, bok);
    check_result("zero_b", lat, 24'h0, 16'h0, 1'b0);
    run_op(16'h0000, 8'hFF, lat, bok);
    check_result("zero_a", lat, 24'h0, 16'h0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    int pulses = 0;
    g_a = 16'd7; g_b = 8'd28; enable = 1'b1;
    @(posedge clk); #1;
    g_a = 16'd1; g_b = 8'd1;
    for (int k = 1; k <= 14; k++) begin
      enable = (k <= 8) ? k[0] : 1'b0;
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++;
    if (pulses !== 1) $display("FAIL ignored pulses: got %0d want 1", pulses); else passed++;
    total++;
    if (product !== 24'd196) $display("FAIL ignored product: got %0d want 196", product); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL ignored idle: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int lat; bit bok;
    g_a = 16'h1234; g_b = 8'h55; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({product, product_sat, overflow, done, busy} !== '0)
      $display("FAIL reset_mid outputs: got p=%h s=%h o=%b d=%b b=%b want all 0",
               product, product_sat, overflow, done, busy);
    else passed++;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL reset_mid no_done: got %0d pulses want 0", pulses); else passed++;
    run_op(16'h0100, 8'h80, lat, bok);
    check_result("after_reset", lat, 24'h008000, 16'h8000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t_first = -1;
    int t_second = -1;
    g_a = 16'd7; g_b = 8'd28; enable = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 30 && t_second < 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t_first < 0) begin
          t_first = k;
          total++;
          if (product !== 24'd196) $display("FAIL b2b first_product: got %0d want 196", product); else passed++;
          total++;
          if (product > 24'd200) $display("FAIL b2b roundtrip: got %0d want <= 200", product); else passed++;
          g_a = 16'h1000; g_b = 8'h10;
        end else begin
          t_second = k;
          enable = 1'b0;
        end
      end
      if (t_first > 0 && k == t_first + 1) enable = 1'b0;
    end
    total++;
    if (t_first !== 9) $display("FAIL b2b first_latency: got %0d want 9", t_first); else passed++;
    total++;
    if (t_second - t_first !== 10) $display("FAIL b2b spacing: got %0d want 10", t_second - t_first); else passed++;
    total++;
    if (product !== 24'h010000) $display("FAIL b2b second_product: got %h want 010000", product); else passed++;
    total++;
    if ({product_sat, overflow} !== {16'hFFFF, 1'b1})
      $display("FAIL b2b second_sat: got %h/%b want ffff/1", product_sat, overflow);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [15:0] a;
    logic [7:0]  b;
    logic [23:0] e_p;
    for (int i = 0; i < 6; i++) begin
      a   = 16'($urandom);
      b   = 8'($urandom);
      e_p = 24'(a) * 24'(b);
      run_op(a, b, lat, bok);
      check_result("random", lat, e_p, (e_p > 24'h00FFFF) ? 16'hFFFF : e_p[15:0],
                   e_p > 24'h00FFFF);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_max();
    test_zero();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_binary_multiplier
